led_pattern_gen: RTL and testbench

Parametrised LED frame generator for the LED display module. Produces a WIDTH-bit LED pattern stepped by an internal frame prescaler. Four selectable animation modes: bouncing bargraph, bouncing dot, rotating chase, blink. Configurable dwell at the bounce endpoints. Drives the LED pins directly and provides frame and wrap strobes for the rest of the display logic.

---
 rtl/led_pattern_gen_if.sv | 27 ++
 rtl/led_pattern_gen.sv | 132 +++++++++++++
 tb/tb_led_pattern_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Control and LED-output bundle for led_pattern_gen.
// The display controller drives the master side; the generator is the slave.
interface led_pattern_gen_if #(
   parameter int WIDTH  = 16,
   parameter int DIV_W  = 24,
   parameter int HOLD_W = 4
);
   logic              en;
   logic              restart;
   logic [1:0]        mode;
   logic [DIV_W-1:0]  div;
   logic [HOLD_W-1:0] hold;
   logic [WIDTH-1:0]  led;
   logic              frame_tick;
   logic              wrap;
   logic              dir;

   modport master (
      output en, restart, mode, div, hold,
      input  led, frame_tick, wrap, dir
   );

   modport slave (
      input  en, restart, mode, div, hold,
      output led, frame_tick, wrap, dir
   );
endinterface

// File: rtl/led_pattern_gen.sv
// LED frame generator: a prescaler paces frame steps, a small IDLE/RUN/DWELL
// machine walks a position counter, and the LED word is decoded from the
// position according to the animation mode latched at the last start load.
module led_pattern_gen #(
   parameter int WIDTH  = 16,
   parameter int DIV_W  = 24,
   parameter int HOLD_W = 4
) (
   input logic         clk,
   input logic         rst_n,
   led_pattern_gen_if.slave bus
);
   localparam int POS_W = $clog2(WIDTH + 1);
   localparam logic [POS_W-1:0] POS_ZERO    = '0;
   localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);
   localparam logic [POS_W-1:0] POS_BAR_TOP = POS_W'(WIDTH);
   localparam logic [POS_W-1:0] POS_DOT_TOP = POS_W'(WIDTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DWELL} state_t;
   typedef enum logic [1:0] {M_BAR, M_DOT, M_CHASE, M_BLINK} mode_t;

   state_t            state_q;
   mode_t             mode_q;
   logic [POS_W-1:0]  pos_q;
   logic              dir_q;
   logic [HOLD_W-1:0] dwell_q;
   logic [DIV_W-1:0]  presc_q;
   logic [WIDTH-1:0]  led_q;
   logic              tick_q;
   logic              wrap_q;

   logic [POS_W-1:0]  pos_d;
   logic              dir_d;
   logic [HOLD_W-1:0] dwell_d;
   state_t            state_d;
   logic [POS_W-1:0]  top;
   logic              at_end;
   logic              start_load;
   logic              term_cnt;

   // LED word for a given mode and position; bit WIDTH-1 is the leftmost LED.
   function automatic logic [WIDTH-1:0] pattern(mode_t m, logic [POS_W-1:0] p);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (m)
            M_BAR:          v[i] = (WIDTH - 1 - i) < int'(p);
            M_DOT, M_CHASE: v[i] = (WIDTH - 1 - i) == int'(p);
            default:        v[i] = (p != POS_ZERO);
         endcase
      end
      return v;
   endfunction

   assign start_load = bus.restart || (bus.en && (state_q == ST_IDLE));
   assign term_cnt   = (presc_q == bus.div);

   // Next position/direction/dwell if a frame step were taken this cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      pos_d   = pos_q;
      dir_d   = dir_q;
      dwell_d = dwell_q;
      state_d = ST_RUN;
      top     = POS_BAR_TOP;
      at_end  = 1'b0;
      case (mode_q)
         M_CHASE: pos_d = (pos_q == POS_DOT_TOP) ? POS_ZERO : pos_q + 1'b1;
         M_BLINK: pos_d = (pos_q == POS_ZERO) ? POS_ONE : POS_ZERO;
         default: begin
            top    = (mode_q == M_BAR) ? POS_BAR_TOP : POS_DOT_TOP;
            at_end = dir_q ? (pos_q == POS_ZERO) : (pos_q == top);
            if (at_end && (dwell_q < bus.hold)) begin
               dwell_d = dwell_q + 1'b1;
               state_d = ST_DWELL;
            end else if (at_end) begin
               dwell_d = '0;
               dir_d   = ~dir_q;
               pos_d   = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
            end else begin
               pos_d   = dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
            end
         end
      endcase
   end

   // Control FSM, prescaler and registered outputs; restart beats en=0 beats a step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= M_BAR;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         dwell_q <= '0;
         presc_q <= '0;
         led_q   <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         if (start_load) begin
            state_q <= ST_RUN;
            mode_q  <= mode_t'(bus.mode);
            pos_q   <= '0;
            dir_q   <= 1'b0;
            dwell_q <= '0;
            presc_q <= '0;
            led_q   <= pattern(mode_t'(bus.mode), POS_ZERO);
         end else if (!bus.en) begin
            state_q <= ST_IDLE;
         end else if (term_cnt) begin
            presc_q <= '0;
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            led_q   <= pattern(mode_q, pos_d);
            tick_q  <= 1'b1;
            wrap_q  <= (pos_d == POS_ZERO) && (pos_q != POS_ZERO);
         end else begin
            presc_q <= presc_q + 1'b1;
         end
      end
   end

   assign bus.led        = led_q;
   assign bus.frame_tick = tick_q;
   assign bus.wrap       = wrap_q;
   assign bus.dir        = dir_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios with literal expectations,
// then randomized control traffic, all compared every cycle against a
// frame-index model of the animations.
module tb_led_pattern_gen;
   localparam int WIDTH  = 16;
   localparam int DIV_W  = 24;
   localparam int HOLD_W = 4;

   typedef struct packed {
      logic [WIDTH-1:0] led;
      logic             dir;
      logic             wrap;
   } frame_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   led_pattern_gen_if #(.WIDTH(WIDTH), .DIV_W(DIV_W), .HOLD_W(HOLD_W)) bus ();

   led_pattern_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W), .HOLD_W(HOLD_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Pattern for a position, straight from the mode definitions.
   function automatic logic [WIDTH-1:0] pat(int md, int p);
      logic [63:0] v;
      case (md)
         0:       v = ((64'd1 << p) - 64'd1) << (WIDTH - p);
         1, 2:    v = 64'd1 << (WIDTH - 1 - p);
         default: v = (p != 0) ? ((64'd1 << WIDTH) - 64'd1) : 64'd0;
      endcase
      return v[WIDTH-1:0];
   endfunction

   // Frame k after a start load (k=0 is the start-load frame), closed form.
   function automatic frame_t frame_of(int md, int h, int k);
      frame_t f;
      int p, top, per, j;
      logic d, w;
      p = 0; d = 1'b0; w = 1'b0;
      if (k > 0) begin
         case (md)
            2: begin p = k % WIDTH; w = (p == 0); end
            3: begin p = k % 2;     w = (p == 0); end
            default: begin
               top = (md == 0) ? WIDTH : WIDTH - 1;
               per = 2 * top + 2 * h;
               j   = (k - 1) % per;
               if (j < top - 1)            begin p = j + 1;                d = 1'b0; end
               else if (j < top + h)       begin p = top;                  d = 1'b0; end
               else if (j < 2 * top + h - 1) begin p = top - 1 - (j - (top + h)); d = 1'b1; end
               else                        begin p = 0;                    d = 1'b1; end
               w = (j == 2 * top + h - 1);
            end
         endcase
      end
      f.led  = pat(md, p);
      f.dir  = d;
      f.wrap = w;
      return f;
   endfunction

   // Reference model: cycles since start load, frames every div+1 cycles.
   logic   m_run  = 1'b0;
   int     m_c    = 0;
   int     m_mode = 0;
   int     m_hold = 0;
   int     m_div  = 0;
   logic   m_tick = 1'b0;
   frame_t m_frame = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run   <= 1'b0;
         m_c     <= 0;
         m_mode  <= 0;
         m_hold  <= 0;
         m_div   <= 0;
         m_tick  <= 1'b0;
         m_frame <= '0;
      end else begin
         m_tick       <= 1'b0;
         m_frame.wrap <= 1'b0;
         if (bus.restart || (bus.en && !m_run)) begin
            m_run   <= 1'b1;
            m_c     <= 0;
            m_mode  <= int'(bus.mode);
            m_hold  <= int'(bus.hold);
            m_div   <= int'(bus.div);
            m_frame <= {pat(int'(bus.mode), 0), 1'b0, 1'b0};
         end else if (!bus.en) begin
            m_run <= 1'b0;
         end else begin
            m_c <= m_c + 1;
            if ((m_c + 1) % (m_div + 1) == 0) begin
               m_tick  <= 1'b1;
               m_frame <= frame_of(m_mode, m_hold, (m_c + 1) / (m_div + 1));
            end
         end
      end
   end

   // Every-cycle comparison of all outputs, away from the active edge.
   always @(negedge clk) begin
      check("led", 64'(bus.led), 64'(m_frame.led));
      check("frame_tick", 64'(bus.frame_tick), 64'(m_tick));
      check("wrap", 64'(bus.wrap), 64'(m_frame.wrap));
      check("dir", 64'(bus.dir), 64'(m_frame.dir));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start(input int md, input int dv, input int hd);
      bus.mode    = 2'(md);
      bus.div     = DIV_W'(dv);
      bus.hold    = HOLD_W'(hd);
      bus.restart = 1'b1;
      bus.en      = 1'b1;
      tick(1);
      bus.restart = 1'b0;
   endtask

   initial begin
      bus.en = 1'b0; bus.restart = 1'b0; bus.mode = '0; bus.div = '0; bus.hold = '0;
      #1 rst_n = 1'b0;
      tick(2);
      check("rst_led", 64'(bus.led), 64'h0);
      rst_n = 1'b1;
      tick(3);
      check("idle_led", 64'(bus.led), 64'h0);

      // BAR bounce, div=0, hold=0
      start(0, 0, 0);
      check("bar_k0_led", 64'(bus.led), 64'h0000);
      check("bar_k0_tick", 64'(bus.frame_tick), 64'h0);
      tick(3);
      check("bar_k3_led", 64'(bus.led), 64'hE000);
      tick(13);
      check("bar_k16_led", 64'(bus.led), 64'hFFFF);
      tick(1);
      check("bar_k17_led", 64'(bus.led), 64'hFFFE);
      check("bar_k17_dir", 64'(bus.dir), 64'h1);
      tick(15);
      check("bar_k32_led", 64'(bus.led), 64'h0000);
      check("bar_k32_wrap", 64'(bus.wrap), 64'h1);
      tick(1);
      check("bar_k33_led", 64'(bus.led), 64'h8000);

      // DOT with hold=2
      start(1, 0, 2);
      check("dot_k0_led", 64'(bus.led), 64'h8000);
      tick(17);
      check("dot_k17_led", 64'(bus.led), 64'h0001);
      check("dot_k17_dir", 64'(bus.dir), 64'h0);
      tick(1);
      check("dot_k18_led", 64'(bus.led), 64'h0002);
      check("dot_k18_dir", 64'(bus.dir), 64'h1);
      tick(16);
      check("dot_k34_led", 64'(bus.led), 64'h8000);
      tick(1);
      check("dot_k35_led", 64'(bus.led), 64'h4000);

      // CHASE with div=3, restart coincident with terminal count
      start(2, 3, 0);
      tick(4);
      check("pre_c4_tick", 64'(bus.frame_tick), 64'h1);
      check("pre_c4_led", 64'(bus.led), 64'h4000);
      tick(3);
      bus.restart = 1'b1;
      tick(1);
      bus.restart = 1'b0;
      check("coll_led", 64'(bus.led), 64'h8000);
      check("coll_tick", 64'(bus.frame_tick), 64'h0);
      tick(4);
      check("coll_c4_led", 64'(bus.led), 64'h4000);

      // Mode change without restart is ignored
      start(2, 0, 0);
      bus.mode = 2'd3;
      tick(5);
      check("modechg_led", 64'(bus.led), 64'h0400);

      // en low freezes, en high starts over (picking up BLINK)
      bus.en = 1'b0;
      tick(10);
      check("freeze_led", 64'(bus.led), 64'h0400);
      bus.en = 1'b1;
      tick(1);
      check("en_load_led", 64'(bus.led), 64'h0000);
      check("en_load_tick", 64'(bus.frame_tick), 64'h0);
      tick(1);
      check("blink_k1_led", 64'(bus.led), 64'hFFFF);
      tick(1);
      check("blink_k2_wrap", 64'(bus.wrap), 64'h1);

      // Asynchronous reset in the middle of the return dwell of DOT
      start(1, 0, 5);
      tick(37);
      check("dwell_led", 64'(bus.led), 64'h8000);
      check("dwell_dir", 64'(bus.dir), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_led", 64'(bus.led), 64'h0);
      check("arst_dir", 64'(bus.dir), 64'h0);
      check("arst_tick", 64'(bus.frame_tick), 64'h0);
      tick(1);
      bus.en = 1'b0;
      rst_n  = 1'b1;
      tick(5);
      check("post_rst_idle_led", 64'(bus.led), 64'h0);
      bus.en = 1'b1;
      tick(1);
      check("post_rst_load_led", 64'(bus.led), 64'h8000);

      // Randomized control traffic
      start(0, 1, 1);
      repeat (3000) begin
         bus.restart = ($urandom_range(0, 40) == 0);
         bus.en      = ($urandom_range(0, 15) != 0);
         bus.mode    = 2'($urandom_range(0, 3));
         if (bus.restart) begin
            bus.div  = DIV_W'($urandom_range(0, 3));
            bus.hold = HOLD_W'($urandom_range(0, 3));
         end
         tick(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
